// File: rtl/btn_debounce.sv
// Multi-channel button synchroniser, debouncer and edge/repeat pulse generator.
// Optional auto-repeat pulses are compiled in with BTN_DEBOUNCE_REPEAT_EN.
module btn_debounce #(
   parameter int NUM_BTN       = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int DB_CYCLES     = 16,
   parameter int REPEAT_DELAY  = 1000,
   parameter int REPEAT_PERIOD = 250
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn,
   output logic [NUM_BTN-1:0] btn_db,
   output logic [NUM_BTN-1:0] btn_re,
   output logic [NUM_BTN-1:0] btn_fe,
   output logic               btn_any_re,
   output logic               btn_any_fe,
   output logic [NUM_BTN-1:0] btn_rpt
);

   localparam int DCW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DCW-1:0] DB_LAST = DCW'(DB_CYCLES - 1);

   if (NUM_BTN < 1 || SYNC_STAGES < 2 || DB_CYCLES < 1 ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("btn_debounce: parameter out of range");
   end

   logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
   logic [NUM_BTN-1:0] s;
   logic [NUM_BTN-1:0] db_q;
   logic [NUM_BTN-1:0] db_nxt;
   logic [NUM_BTN-1:0] re_q;
   logic [NUM_BTN-1:0] fe_q;
   logic [DCW-1:0]     cnt_q [NUM_BTN];

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= btn;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   // A new level is accepted on the DB_CYCLES-th consecutive mismatch.
   always_comb begin
      db_nxt = db_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (s[i] != db_q[i] && cnt_q[i] == DB_LAST) db_nxt[i] = s[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (s[i] == db_q[i] || cnt_q[i] == DB_LAST) cnt_q[i] <= '0;
            else cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_q <= '0;
         re_q <= '0;
         fe_q <= '0;
      end else begin
         db_q <= db_nxt;
         re_q <= db_nxt & ~db_q;
         fe_q <= ~db_nxt & db_q;
      end
   end

   assign btn_db     = db_q;
   assign btn_re     = re_q;
   assign btn_fe     = fe_q;
   assign btn_any_re = |re_q;
   assign btn_any_fe = |fe_q;

`ifdef BTN_DEBOUNCE_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RCW  = $clog2(RMAX + 1);
   localparam logic [RCW-1:0] RC_ONE = RCW'(1);

   logic [RCW-1:0]     rc_q [NUM_BTN];
   logic [NUM_BTN-1:0] rpt_q;

   // Down-counter to the next repeat; a falling level clears it at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rpt_q <= '0;
         for (int i = 0; i < NUM_BTN; i++) rc_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            rpt_q[i] <= 1'b0;
            if (db_nxt[i] && !db_q[i]) begin
               rc_q[i] <= RCW'(REPEAT_DELAY);
            end else if (db_nxt[i] && db_q[i]) begin
               if (rc_q[i] == RC_ONE) begin
                  rpt_q[i] <= 1'b1;
                  rc_q[i]  <= RCW'(REPEAT_PERIOD);
               end else begin
                  rc_q[i] <= rc_q[i] - 1'b1;
               end
            end else begin
               rc_q[i] <= '0;
            end
         end
      end
   end

   assign btn_rpt = rpt_q;
`else
   assign btn_rpt = '0;
`endif

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Parametrised multi-channel button conditioner: it synchronises raw asynchronous button inputs, debounces each channel independently, and emits per-channel single-cycle rising/falling edge pulses plus OR-reduced summary pulses. It sits between board pins and control logic (mode select, single-step, reset request) and replaces plain register-compare edge detection on noisy mechanical inputs. An optional auto-repeat generator produces periodic pulses while a button is held.

## Interface
- `NUM_BTN`, default 4: number of independent button channels (≥1).
- `SYNC_STAGES`, default 2: synchroniser flop depth per channel (≥2).
- `DB_CYCLES`, default 16: consecutive cycles a new synchronised level must persist before acceptance (≥1).
- `REPEAT_DELAY`, default 1000: cycles from press acceptance to first repeat pulse (≥1; used only with repeat compiled in).
- `REPEAT_PERIOD`, default 250: cycles between subsequent repeat pulses (≥1; used only with repeat compiled in).
- `clk` in 1: sole clock; every flop is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn` in NUM_BTN: raw asynchronous button levels, 1 = pressed.
- `btn_db` out NUM_BTN: debounced level per channel.
- `btn_re` out NUM_BTN: one-cycle pulse on the first cycle that `btn_db[i]` is 1.
- `btn_fe` out NUM_BTN: one-cycle pulse on the first cycle that `btn_db[i]` is 0 after being 1.
- `btn_any_re` out 1: OR of `btn_re`.
- `btn_any_fe` out 1: OR of `btn_fe`.
- `btn_rpt` out NUM_BTN: auto-repeat pulses; constant 0 when repeat is compiled out.

## Operation
- Reset (async assert, release synchronous to `clk`): synchroniser flops, `btn_db`, debounce counters and repeat counters clear to 0. Every output reads 0 while `rst` is high.
- Synchroniser: `SYNC_STAGES` flops per channel. `s[i]` is the last stage.
- Debounce, per channel: counter of width clog2(DB_CYCLES), minimum 1.
  - `s[i] == btn_db[i]`: counter ← 0.
  - `s[i] != btn_db[i]` and counter < DB_CYCLES-1: counter increments.
  - `s[i] != btn_db[i]` and counter == DB_CYCLES-1: `btn_db[i]` ← `s[i]`, counter ← 0.
  - A mismatch shorter than DB_CYCLES cycles is discarded; the next mismatch restarts from 0.
- Edges: `btn_re` and `btn_fe` are registered and coincident with the `btn_db` transition cycle. `btn_re[i] & btn_fe[i]` is never 1.
- Channels are fully independent. Simultaneous edges on several channels assert several bits; the `any` outputs assert once per cycle.
- Reset mid-debounce discards the partial count. A button held through reset release produces a fresh `btn_re` after the full latency, because `btn_db` restarts at 0.

## Timing
- `btn` changes before edge 1 and then stays stable:
  - `s` updates at edge SYNC_STAGES.
  - `btn_db`, `btn_re` and `btn_fe` update at edge SYNC_STAGES+DB_CYCLES.
  - With the defaults this is edge 18.
- Edge pulses last exactly 1 cycle. Minimum spacing between a `btn_re` and the following `btn_fe` on a channel is DB_CYCLES cycles.
- Repeat: if `btn_re[i]` is in cycle T, `btn_rpt[i]` pulses at T+REPEAT_DELAY, then every REPEAT_PERIOD cycles while `btn_db[i]` stays 1.
  - Falling `btn_db[i]` clears the repeat counter immediately.
  - If `btn_fe[i]` and a scheduled repeat fall in the same cycle, no repeat pulse is issued.

## Configuration
- `BTN_DEBOUNCE_REPEAT_EN` defined: per-channel repeat counters (width clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)) and `btn_rpt` behaviour as above.
- Not defined: no repeat logic is instantiated, `btn_rpt` is tied to 0, and REPEAT_* parameters are ignored.

## Test plan
- Defaults: reset, then hold `btn`=0001. Required: `btn_db[0]`/`btn_re[0]`/`btn_any_re` rise at edge 18 after the change; `btn_re` is high for 1 cycle; other bits stay 0.
- Glitch: pulse `btn[1]` high for 10 cycles, low for 3 cycles, then high for 10 cycles (DB_CYCLES=16). Required: `btn_db[1]` and `btn_re[1]` never assert.
- Release: from `btn_db`=0001, drop `btn[0]`. Required: `btn_fe[0]` and `btn_any_fe` pulse 1 cycle at edge 18; `btn_db`=0000 thereafter.
- Simultaneous: `btn` 0000→1010 in one cycle. Required: `btn_re`=1010 for exactly 1 cycle; `btn_any_re` pulses once.
- Reset mid-operation: assert `rst` at count 8 while `btn[2]`=1, release after 3 cycles. Required: all outputs read 0 during reset; `btn_re[2]` fires 18 edges after release.
- Repeat (macro defined, REPEAT_DELAY=20, REPEAT_PERIOD=5): hold `btn[3]` for 40 cycles after `btn_re[3]`. Required: `btn_rpt[3]` pulses at +20, +25, +30, +35 and stops on release. With the macro undefined, `btn_rpt` stays 0.
